sram_ctrl: RTL

- Synchronous, parametrised controller for an asynchronous SRAM with active-low ceb/web/oeb strobes and a shared bidirectional data bus.
- Converts single-cycle host requests (req/ready handshake) into correctly timed SRAM read and write cycles.
- Wait states are programmable, and a bus turnaround gap is inserted after each read.
- Sits between a clocked host/bus master and the external SRAM device.

---
 rtl/sram_ctrl_if.sv | 25 ++
 rtl/sram_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sram_ctrl_if.sv
// Host-side request/response bundle for sram_ctrl: single-cycle req/ready
// handshake plus read-data and write-completion pulses.
interface sram_ctrl_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          wdone;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata, wdone
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata, wdone
    );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: turns accepted host requests into timed
// ceb/web/oeb cycles with programmable waits and a post-read bus turnaround.
module sram_ctrl #(
    parameter int unsigned AW      = 15,
    parameter int unsigned DW      = 8,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2,
    parameter int unsigned TURN    = 1
) (
    input  logic          clk,
    input  logic          rstb,
    sram_ctrl_if.slave    host,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_data,
    output logic          ceb,
    output logic          web,
    output logic          oeb
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WHOLD,
        S_RD,
        S_TURN
    } state_e;

    localparam logic [7:0] RD_W = 8'(RD_WAIT);
    localparam logic [7:0] WR_W = 8'(WR_WAIT);
    localparam logic [7:0] TN_W = 8'(TURN);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          wdone_q, wdone_d;
    logic          ceb_q, ceb_d;
    logic          web_q, web_d;
    logic          oeb_q, oeb_d;
    logic          bus_oe;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (host.req) begin
                    addr_d  = host.addr;
                    wdata_d = host.wdata;
                    cnt_d   = 8'd1;
                    state_d = host.we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (cnt_q == WR_W) state_d = S_WHOLD;
                else               cnt_d   = cnt_q + 8'd1;
            end
            S_WHOLD: begin
                state_d = S_IDLE;
                wdone_d = 1'b1;
            end
            S_RD: begin
                if (cnt_q == RD_W) begin
                    rdata_d  = sram_data;
                    rvalid_d = 1'b1;
                    if (TURN > 0) begin
                        state_d = S_TURN;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_TURN: begin
                if (cnt_q == TN_W) state_d = S_IDLE;
                else               cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
        // Strobes are decoded from the next state so they change on the same edge as the FSM.
        ceb_d = !(state_d == S_WR || state_d == S_RD);
        web_d = (state_d != S_WR);
        oeb_d = (state_d != S_RD);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            ceb_q    <= 1'b1;
            web_q    <= 1'b1;
            oeb_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            ceb_q    <= ceb_d;
            web_q    <= web_d;
            oeb_q    <= oeb_d;
        end
    end

    // Data is held through WHOLD so it stays valid past the rising web edge.
    assign bus_oe    = (state_q == S_WR) || (state_q == S_WHOLD);
    assign sram_data = bus_oe ? wdata_q : 'z;

    assign sram_addr   = addr_q;
    assign ceb         = ceb_q;
    assign web         = web_q;
    assign oeb         = oeb_q;
    assign host.ready  = (state_q == S_IDLE);
    assign host.rvalid = rvalid_q;
    assign host.rdata  = rdata_q;
    assign host.wdone  = wdone_q;
endmodule
